// File: rtl/pll_relock_pkg.sv
// Shared definitions for the PLL relock controller: state encoding,
// timer width and the default parameter values.
package pll_relock_pkg;

    localparam int TIMER_W = 12;

    localparam logic [2:0] STATE_IDLE     = 3'd0;
    localparam logic [2:0] STATE_DEBOUNCE = 3'd1;
    localparam logic [2:0] STATE_RESET    = 3'd2;
    localparam logic [2:0] STATE_CAL      = 3'd3;
    localparam logic [2:0] STATE_LOCK     = 3'd4;
    localparam logic [2:0] STATE_DONE     = 3'd5;
    localparam logic [2:0] STATE_FAIL     = 3'd6;

    typedef enum logic [2:0] {
        IDLE     = STATE_IDLE,
        DEBOUNCE = STATE_DEBOUNCE,
        RESET    = STATE_RESET,
        CAL      = STATE_CAL,
        LOCK     = STATE_LOCK,
        DONE     = STATE_DONE,
        FAIL     = STATE_FAIL
    } relockStateT;

    localparam int DEF_DEBOUNCE_CYCLES = 8;
    localparam int DEF_RESET_CYCLES    = 4;
    localparam int DEF_CAL_TIMEOUT     = 4095;
    localparam int DEF_LOCK_TIMEOUT    = 4095;
    localparam int DEF_MAX_RETRY       = 3;

endpackage

// File: rtl/bit_sync2.sv
// Two-flop synchronizer clocked on the falling edge, cleared asynchronously.
module bit_sync2 (
    input  logic clk,
    input  logic clr,
    input  logic din,
    output logic dout
);

    logic meta;

    // Shift the asynchronous input through two flops to settle metastability.
    always_ff @(negedge clk or posedge clr) begin
        if (clr) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/pll_relock_controller.sv
// PLL relock sequencer: detects a debounced loss of lock, then drives the
// PLL through reset, calibration and lock with bounded retries.
//
// state    | meaning
// IDLE     | locked or auto-relock disabled, watching for unlock
// DEBOUNCE | unlock seen, waiting for it to persist
// RESET    | pllReset held high for RESET_CYCLES
// CAL      | calibration started, waiting for calDone
// LOCK     | lock detector released, waiting for lock
// DONE     | one-cycle success, counts the relock
// FAIL     | retries exhausted, waits for forceRelock or POR
module pll_relock_controller
    import pll_relock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int RESET_CYCLES    = DEF_RESET_CYCLES,
    parameter int CAL_TIMEOUT     = DEF_CAL_TIMEOUT,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int MAX_RETRY       = DEF_MAX_RETRY
) (
    input  logic        clk40Ref,
    input  logic        POR,
    input  logic        enable,
    input  logic        forceRelock,
    input  logic        pllLocked,
    input  logic        pllCalibrationDone,
    output logic        pllReset,
    output logic        startCalibration,
    output logic        resetLockDetect,
    output logic [2:0]  state,
    output logic        busy,
    output logic [3:0]  retryCount,
    output logic [11:0] relockCount,
    output logic        fail,
    output logic        relockDone
);

    localparam logic [TIMER_W-1:0] DEB_LAST  = TIMER_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] RST_LAST  = TIMER_W'(RESET_CYCLES - 1);
    localparam logic [TIMER_W-1:0] CAL_LAST  = TIMER_W'(CAL_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [3:0]         RETRY_MAX = 4'(MAX_RETRY);

    relockStateT        curState;
    relockStateT        nextState;
    logic [TIMER_W-1:0] timer;
    logic               lockedS;
    logic               calDoneS;
    logic               forced;
    logic               timeoutHit;
    logic               retryInc;

    bit_sync2 uLockSync (
        .clk  (clk40Ref),
        .clr  (POR),
        .din  (pllLocked),
        .dout (lockedS)
    );

    bit_sync2 uCalSync (
        .clk  (clk40Ref),
        .clr  (POR),
        .din  (pllCalibrationDone),
        .dout (calDoneS)
    );

    assign state = curState;

    // Next-state decode; forceRelock outranks every other transition.
    always_comb begin
        nextState  = curState;
        timeoutHit = 1'b0;
        retryInc   = 1'b0;
        forced     = forceRelock && (curState != RESET);
        if (forced) begin
            nextState = RESET;
        end else begin
            case (curState)
                IDLE:     if (enable && !lockedS) nextState = DEBOUNCE;
                DEBOUNCE: begin
                    if (lockedS || !enable)  nextState = IDLE;
                    else if (timer == DEB_LAST) nextState = RESET;
                end
                RESET:    if (timer == RST_LAST) nextState = CAL;
                CAL: begin
                    if (calDoneS)              nextState = LOCK;
                    else if (timer == CAL_LAST) timeoutHit = 1'b1;
                end
                LOCK: begin
                    if (lockedS)                nextState = DONE;
                    else if (timer == LOCK_LAST) timeoutHit = 1'b1;
                end
                DONE:     nextState = IDLE;
                FAIL:     nextState = FAIL;
                default:  nextState = IDLE;
            endcase
            if (timeoutHit) begin
                if (retryCount < RETRY_MAX) begin
                    nextState = RESET;
                    retryInc  = 1'b1;
                end else begin
                    nextState = FAIL;
                end
            end
        end
    end

    // State, timer, counters and registered output decode of the next state.
    always_ff @(negedge clk40Ref or posedge POR) begin
        if (POR) begin
            curState         <= IDLE;
            timer            <= '0;
            pllReset         <= 1'b0;
            startCalibration <= 1'b1;
            resetLockDetect  <= 1'b1;
            busy             <= 1'b0;
            retryCount       <= '0;
            relockCount      <= '0;
            fail             <= 1'b0;
            relockDone       <= 1'b0;
        end else begin
            curState <= nextState;
            if (nextState != curState)     timer <= '0;
            else if (timer != '1)          timer <= timer + 1'b1;

            pllReset         <= (nextState == RESET);
            startCalibration <= (nextState != RESET);
            resetLockDetect  <= (nextState != RESET) && (nextState != CAL);
            busy             <= (nextState == RESET) || (nextState == CAL) ||
                                (nextState == LOCK)  || (nextState == DONE);
            relockDone       <= (nextState == DONE);

            if (forced) begin
                retryCount <= '0;
                fail       <= 1'b0;
            end else if (retryInc) begin
                retryCount <= retryCount + 1'b1;
            end else if (nextState == DONE) begin
                retryCount <= '0;
                if (relockCount != 12'hFFF) relockCount <= relockCount + 1'b1;
            end else if (nextState == FAIL) begin
                fail <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pll_relock_controller.sv
// Directed bench for pll_relock_controller with short timeouts.
module tb_pll_relock_controller;

    logic        clk40Ref;
    logic        POR;
    logic        enable;
    logic        forceRelock;
    logic        pllLocked;
    logic        pllCalibrationDone;
    logic        pllReset;
    logic        startCalibration;
    logic        resetLockDetect;
    logic [2:0]  state;
    logic        busy;
    logic [3:0]  retryCount;
    logic [11:0] relockCount;
    logic        fail;
    logic        relockDone;

    int checks = 0;
    int errors = 0;

    int rstHighCnt = 0;
    int rstRiseCnt = 0;
    int doneCnt    = 0;
    int maxState   = 0;
    logic prevRst  = 1'b0;

    pll_relock_controller #(
        .DEBOUNCE_CYCLES (4),
        .RESET_CYCLES    (4),
        .CAL_TIMEOUT     (16),
        .LOCK_TIMEOUT    (16),
        .MAX_RETRY       (2)
    ) dut (
        .clk40Ref           (clk40Ref),
        .POR                (POR),
        .enable             (enable),
        .forceRelock        (forceRelock),
        .pllLocked          (pllLocked),
        .pllCalibrationDone (pllCalibrationDone),
        .pllReset           (pllReset),
        .startCalibration   (startCalibration),
        .resetLockDetect    (resetLockDetect),
        .state              (state),
        .busy               (busy),
        .retryCount         (retryCount),
        .relockCount        (relockCount),
        .fail               (fail),
        .relockDone         (relockDone)
    );

    // 20-unit reference clock; DUT acts on the falling edge.
    initial clk40Ref = 1'b0;
    always #10 clk40Ref = ~clk40Ref;

    // Output monitor sampled on the rising edge, half a period from DUT updates.
    always @(posedge clk40Ref) begin
        if (pllReset) rstHighCnt = rstHighCnt + 1;
        if (pllReset && !prevRst) rstRiseCnt = rstRiseCnt + 1;
        prevRst = pllReset;
        if (relockDone) doneCnt = doneCnt + 1;
        if (int'(state) > maxState) maxState = int'(state);
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk40Ref);
        #1;
    endtask

    task automatic clearMon();
        rstHighCnt = 0;
        rstRiseCnt = 0;
        doneCnt    = 0;
        maxState   = 0;
    endtask

    task automatic waitState(input logic [2:0] s, input int maxCyc, input string tag);
        int n;
        n = 0;
        while (state != s && n < maxCyc) begin
            tick();
            n++;
        end
        checkVal(tag, state, s);
    endtask

    task automatic nominalFromCal(input string tag);
        waitState(3'd3, 60, {tag, "_reachCal"});
        repeat (5) tick();
        pllCalibrationDone = 1'b1;
        waitState(3'd4, 20, {tag, "_reachLock"});
        pllCalibrationDone = 1'b0;
        repeat (3) tick();
        pllLocked = 1'b1;
        waitState(3'd0, 20, {tag, "_backIdle"});
    endtask

    initial begin
        int n;
        int bad;
        POR = 1'b1;
        enable = 1'b0;
        forceRelock = 1'b0;
        pllLocked = 1'b1;
        pllCalibrationDone = 1'b0;
        repeat (3) tick();

        checkVal("rst_state", state, 0);
        checkVal("rst_pllReset", pllReset, 0);
        checkVal("rst_startCal", startCalibration, 1);
        checkVal("rst_resetLockDetect", resetLockDetect, 1);
        checkVal("rst_busy", busy, 0);
        checkVal("rst_retry", retryCount, 0);
        checkVal("rst_relockCount", relockCount, 0);
        checkVal("rst_fail", fail, 0);
        checkVal("rst_relockDone", relockDone, 0);

        POR = 1'b0;
        repeat (4) tick();
        enable = 1'b1;
        repeat (4) tick();
        checkVal("idle_locked", state, 0);

        // Glitch: three low cycles never reach RESET.
        clearMon();
        pllLocked = 1'b0;
        repeat (3) tick();
        pllLocked = 1'b1;
        repeat (20) tick();
        checkVal("glitch_rstHigh", rstHighCnt, 0);
        checkVal("glitch_maxState", maxState, 1);
        checkVal("glitch_state", state, 0);
        checkVal("glitch_relockCount", relockCount, 0);

        // Nominal relock with debounce latency measurement.
        clearMon();
        pllLocked = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (!pllReset && n < 30);
        checkVal("nom_debounceLatency", n, 7);
        nominalFromCal("nom");
        checkVal("nom_rstHigh", rstHighCnt, 4);
        checkVal("nom_doneCnt", doneCnt, 1);
        checkVal("nom_relockCount", relockCount, 1);
        checkVal("nom_retry", retryCount, 0);
        checkVal("nom_fail", fail, 0);
        checkVal("nom_busy", busy, 0);

        // Retry exhaustion: calibration never completes.
        clearMon();
        pllLocked = 1'b0;
        waitState(3'd6, 400, "exh_reachFail");
        checkVal("exh_fail", fail, 1);
        checkVal("exh_retry", retryCount, 2);
        checkVal("exh_attempts", rstRiseCnt, 3);
        checkVal("exh_busy", busy, 0);
        bad = 0;
        enable = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 40) pllLocked = 1'b1;
            if (i == 50) enable = 1'b1;
            if (i == 70) pllLocked = 1'b0;
            tick();
            if (state != 3'd6) bad++;
        end
        checkVal("exh_stayFail", bad, 0);
        checkVal("exh_failSticky", fail, 1);

        // Recovery via forceRelock; a second request inside RESET is ignored.
        clearMon();
        forceRelock = 1'b1;
        tick();
        forceRelock = 1'b0;
        checkVal("rec_state", state, 2);
        checkVal("rec_fail", fail, 0);
        checkVal("rec_retry", retryCount, 0);
        forceRelock = 1'b1;
        tick();
        forceRelock = 1'b0;
        checkVal("rec_inReset", state, 2);
        nominalFromCal("rec");
        checkVal("rec_rstHigh", rstHighCnt, 4);
        checkVal("rec_doneCnt", doneCnt, 1);
        checkVal("rec_relockCount", relockCount, 2);
        checkVal("rec_failClear", fail, 0);

        // Coincidence: calDone_s rises on the second attempt's timeout cycle.
        pllLocked = 1'b0;
        waitState(3'd3, 60, "coin_cal1");
        waitState(3'd2, 40, "coin_retry1");
        checkVal("coin_retryBefore", retryCount, 1);
        waitState(3'd3, 20, "coin_cal2");
        repeat (13) tick();
        pllCalibrationDone = 1'b1;
        n = 0;
        while (state == 3'd3 && n < 10) begin
            tick();
            n++;
        end
        checkVal("coin_toLock", state, 4);
        checkVal("coin_retryKept", retryCount, 1);
        pllCalibrationDone = 1'b0;
        repeat (2) tick();
        pllLocked = 1'b1;
        waitState(3'd0, 20, "coin_backIdle");
        checkVal("coin_relockCount", relockCount, 3);
        checkVal("coin_retryCleared", retryCount, 0);

        // Abort: POR during CAL resets everything at once.
        pllLocked = 1'b0;
        waitState(3'd3, 60, "abort_reachCal");
        repeat (3) tick();
        #3;
        POR = 1'b1;
        #1;
        checkVal("abort_state", state, 0);
        checkVal("abort_pllReset", pllReset, 0);
        checkVal("abort_startCal", startCalibration, 1);
        checkVal("abort_resetLockDetect", resetLockDetect, 1);
        checkVal("abort_busy", busy, 0);
        checkVal("abort_relockCount", relockCount, 0);
        checkVal("abort_retry", retryCount, 0);
        checkVal("abort_relockDone", relockDone, 0);
        pllLocked = 1'b1;
        enable = 1'b0;
        clearMon();
        repeat (3) tick();
        POR = 1'b0;
        repeat (20) tick();
        checkVal("abort_noDone", doneCnt, 0);
        checkVal("abort_idle", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
